axi_ram_slave: RTL and testbench

//  AXI3 responder backed by on-chip byte-writable RAM; the memory end of the CPU's AXI master port.

---
 rtl/axi_ram_slave_pkg.sv | 33 +++
 rtl/axi_ram_slave_if.sv | 78 +++++++
 rtl/axi_ram_slave_bytewe.sv | 46 ++++
 rtl/axi_ram_slave.sv | 208 ++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared definitions for the AXI3 RAM responder.
//   - AXI burst type codes (FIXED / INCR / WRAP; 2'b11 is treated like INCR)
//   - AXI response codes (OKAY / SLVERR)
//   - Channel widths used by the interface
//   - FSM state encoding
//   - Helper that tells whether a burst type advances the word index
package axi_ram_slave_pkg;

    localparam int ID_WIDTH   = 4;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_WRESP = 2'd3
    } state_t;

    // Only FIXED holds the address; INCR, WRAP and the reserved code all
    // step one word per beat (WRAP is deliberately simplified to INCR).
    function automatic logic burst_advances(input logic [1:0] burst);
        return burst != BURST_FIXED;
    endfunction

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI3 bus bundle between a master and the RAM responder.
//   AR: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid / arready
//   R : rid, rdata, rresp, rlast, rvalid / rready
//   AW: awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid / awready
//   W : wid, wdata, wstrb, wlast, wvalid / wready
//   B : bid, bresp, bvalid / bready
// Modports: master drives the request side, slave drives ready/response side.
interface axi_ram_slave_if;
    import axi_ram_slave_pkg::*;

    logic [ID_WIDTH-1:0]   arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [1:0]            arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    logic [ID_WIDTH-1:0]   awid;
    logic [31:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [1:0]            awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [ID_WIDTH-1:0]   wid;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_ram_slave_bytewe.sv
// Single-port synchronous RAM, 32-bit words with four byte-lane write enables.
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (clears the read register only)
//   addr   in   word index
//   re     in   read enable; rdata updates on the next edge
//   we     in   per-byte write enables
//   wdata  in   write data
//   rdata  out  registered read data, held while re is low
module axi_ram_slave_bytewe #(
    parameter int ADDR_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_reg;

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= mem[addr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 responder backed by a byte-writable on-chip RAM.
//   aclk     in   clock
//   aresetn  in   synchronous active-low reset
//   axi      slave modport of axi_ram_slave_if (AR/R/AW/W/B channels)
// One transaction at a time; AR and AW are arbitrated round-robin in IDLE.
// The RAM holds 2^ADDR_WIDTH words; address bits above the word index are
// ignored, so the space aliases. Sizes are ignored: reads return full words,
// writes are masked by wstrb.
module axi_ram_slave
    import axi_ram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter     INIT_FILE  = ""
) (
    input  logic           aclk,
    input  logic           aresetn,
    axi_ram_slave_if.slave axi
);

    state_t                  state_reg, state_next;
    logic                    prio_w_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [ADDR_WIDTH-1:0]   idx_adv;
    logic [7:0]              beats_reg;     // beats remaining after the current one
    logic [1:0]              burst_reg;
    logic [ID_WIDTH-1:0]     rid_reg;
    logic [ID_WIDTH-1:0]     bid_reg;
    logic                    rlast_reg;
    logic                    err_reg;

    logic                    ar_hs, aw_hs, r_hs, w_hs;
    logic                    w_last_beat;
    logic                    ram_re;
    logic [3:0]              ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [31:0]             ram_rdata;
    logic                    unused_bits;

    // ------------------------------------------------------------------
    // Handshakes and address stepping
    // ------------------------------------------------------------------
    assign ar_hs       = axi.arvalid & axi.arready;
    assign aw_hs       = axi.awvalid & axi.awready;
    assign r_hs        = axi.rvalid  & axi.rready;
    assign w_hs        = axi.wvalid  & axi.wready;
    assign w_last_beat = (beats_reg == 8'd0);

    // Natural overflow of idx_reg gives the modulo-2^ADDR_WIDTH wrap.
    assign idx_adv = burst_advances(burst_reg) ? idx_reg + 1'b1 : idx_reg;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (ar_hs) begin
                    state_next = ST_RD;
                end else if (aw_hs) begin
                    state_next = ST_WR;
                end
            end
            ST_RD: begin
                if (r_hs && rlast_reg) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WR: begin
                // Burst length comes from awlen; wlast does not end it.
                if (w_hs && w_last_beat) begin
                    state_next = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (axi.bready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (readies and valids are pure functions of state)
    // ------------------------------------------------------------------
    always_comb begin
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // The two readies are mutually exclusive whenever both
                // valids are high, so at most one grant per cycle.
                axi.arready = ~(axi.awvalid & prio_w_reg);
                axi.awready = ~(axi.arvalid & ~prio_w_reg);
            end
            ST_RD:    axi.rvalid = 1'b1;
            ST_WR:    axi.wready = 1'b1;
            ST_WRESP: axi.bvalid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            prio_w_reg <= 1'b0;
            idx_reg    <= '0;
            beats_reg  <= '0;
            burst_reg  <= BURST_INCR;
            rid_reg    <= '0;
            bid_reg    <= '0;
            rlast_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (ar_hs) begin
                prio_w_reg <= 1'b1;
                rid_reg    <= axi.arid;
                idx_reg    <= axi.araddr[ADDR_WIDTH+1:2];
                beats_reg  <= axi.arlen;
                burst_reg  <= axi.arburst;
                rlast_reg  <= (axi.arlen == 8'd0);
            end else if (aw_hs) begin
                prio_w_reg <= 1'b0;
                bid_reg    <= axi.awid;
                idx_reg    <= axi.awaddr[ADDR_WIDTH+1:2];
                beats_reg  <= axi.awlen;
                burst_reg  <= axi.awburst;
                err_reg    <= 1'b0;
            end else if (r_hs) begin
                if (rlast_reg) begin
                    rlast_reg <= 1'b0;
                end else begin
                    idx_reg   <= idx_adv;
                    beats_reg <= beats_reg - 8'd1;
                    rlast_reg <= (beats_reg == 8'd1);
                end
            end else if (w_hs) begin
                idx_reg   <= idx_adv;
                beats_reg <= beats_reg - 8'd1;
                // Sticky: an early or missing wlast on any beat flags the burst.
                err_reg   <= err_reg | (axi.wlast != w_last_beat);
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM port: AR handshake reads the first word straight from araddr;
    // each accepted non-last R beat prefetches the following word so the
    // next beat is ready one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr = idx_reg;
        if (ar_hs) begin
            ram_addr = axi.araddr[ADDR_WIDTH+1:2];
        end else if (state_reg == ST_RD) begin
            ram_addr = idx_adv;
        end
    end

    assign ram_re = ar_hs | (r_hs & ~rlast_reg);
    assign ram_we = w_hs ? axi.wstrb : 4'b0000;

    axi_ram_slave_bytewe #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk   (aclk),
        .rst_n (aresetn),
        .addr  (ram_addr),
        .re    (ram_re),
        .we    (ram_we),
        .wdata (axi.wdata),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Response channel outputs
    // ------------------------------------------------------------------
    assign axi.rdata = ram_rdata;
    assign axi.rid   = rid_reg;
    assign axi.rresp = RESP_OKAY;
    assign axi.rlast = rlast_reg;
    assign axi.bid   = bid_reg;
    assign axi.bresp = err_reg ? RESP_SLVERR : RESP_OKAY;

    // Inputs that are accepted but have no effect on behaviour.
    assign unused_bits = ^{axi.araddr, axi.awaddr, axi.arsize, axi.awsize,
                           axi.arlock, axi.arcache, axi.arprot,
                           axi.awlock, axi.awcache, axi.awprot, axi.wid};

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: drives the master side of the bus
// interface, checks each result with an immediate assertion and prints one
// line per bus transaction plus a final summary.
module tb_axi_ram_slave;
    import axi_ram_slave_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [31:0] d;
    logic [31:0] d_hold;
    logic        last;
    logic [3:0]  id;
    logic [1:0]  resp;

    always #5 aclk = ~aclk;

    axi_ram_slave_if axi ();

    axi_ram_slave dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .axi     (axi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic ar_send(input logic [3:0] id_i, input logic [31:0] addr_i,
                           input logic [7:0] len_i, input logic [1:0] burst_i);
        int n = 0;
        axi.arid = id_i; axi.araddr = addr_i; axi.arlen = len_i;
        axi.arburst = burst_i; axi.arvalid = 1'b1;
        #1;
        while (!axi.arready && n < 20) begin
            tick();
            n++;
        end
        check("ar_accept", 32'(n < 20), 32'd1);
        tick();
        axi.arvalid = 1'b0;
        $display("AR id=%0d addr=%h len=%0d burst=%0d", id_i, addr_i, len_i, burst_i);
    endtask

    task automatic r_take(output logic [31:0] data_o, output logic last_o, output logic [3:0] id_o);
        int n = 0;
        while (!axi.rvalid && n < 20) begin
            tick();
            n++;
        end
        check("r_wait", 32'(n < 20), 32'd1);
        data_o = axi.rdata; last_o = axi.rlast; id_o = axi.rid;
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
        $display("R  id=%0d data=%h last=%0d", id_o, data_o, last_o);
    endtask

    task automatic aw_send(input logic [3:0] id_i, input logic [31:0] addr_i,
                           input logic [7:0] len_i, input logic [1:0] burst_i);
        int n = 0;
        axi.awid = id_i; axi.awaddr = addr_i; axi.awlen = len_i;
        axi.awburst = burst_i; axi.awvalid = 1'b1;
        #1;
        while (!axi.awready && n < 20) begin
            tick();
            n++;
        end
        check("aw_accept", 32'(n < 20), 32'd1);
        tick();
        axi.awvalid = 1'b0;
        $display("AW id=%0d addr=%h len=%0d burst=%0d", id_i, addr_i, len_i, burst_i);
    endtask

    task automatic w_beat(input logic [31:0] data_i, input logic [3:0] strb_i, input logic last_i);
        int n = 0;
        axi.wdata = data_i; axi.wstrb = strb_i; axi.wlast = last_i; axi.wvalid = 1'b1;
        #1;
        while (!axi.wready && n < 20) begin
            tick();
            n++;
        end
        check("w_accept", 32'(n < 20), 32'd1);
        tick();
        axi.wvalid = 1'b0;
        $display("W  data=%h strb=%b last=%0d", data_i, strb_i, last_i);
    endtask

    task automatic b_take(output logic [3:0] id_o, output logic [1:0] resp_o);
        int n = 0;
        axi.bready = 1'b1;
        #1;
        while (!axi.bvalid && n < 20) begin
            tick();
            n++;
        end
        check("b_wait", 32'(n < 20), 32'd1);
        id_o = axi.bid; resp_o = axi.bresp;
        tick();
        axi.bready = 1'b0;
        $display("B  id=%0d resp=%b", id_o, resp_o);
    endtask

    task automatic wr1(input logic [31:0] addr_i, input logic [31:0] data_i, input logic [3:0] strb_i);
        logic [3:0] bid_l;
        logic [1:0] bresp_l;
        aw_send(4'd0, addr_i, 8'd0, BURST_INCR);
        w_beat(data_i, strb_i, 1'b1);
        b_take(bid_l, bresp_l);
        check("wr1_bresp", 32'(bresp_l), 32'(RESP_OKAY));
    endtask

    task automatic rd1(input logic [31:0] addr_i, output logic [31:0] data_o);
        logic       last_l;
        logic [3:0] id_l;
        ar_send(4'd0, addr_i, 8'd0, BURST_INCR);
        r_take(data_o, last_l, id_l);
    endtask

    initial begin
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2; axi.arburst = BURST_INCR;
        axi.arlock = '0; axi.arcache = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
        axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'd2; axi.awburst = BURST_INCR;
        axi.awlock = '0; axi.awcache = '0; axi.awprot = '0; axi.awvalid = 1'b0;
        axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
        axi.bready = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_rvalid", 32'(axi.rvalid), 32'd0);
        check("rst_wready", 32'(axi.wready), 32'd0);
        check("rst_bvalid", 32'(axi.bvalid), 32'd0);
        check("rst_rlast",  32'(axi.rlast),  32'd0);
        check("rst_rdata",  axi.rdata,       32'd0);
        check("rst_rid",    32'(axi.rid),    32'd0);
        check("rst_bid",    32'(axi.bid),    32'd0);
        check("rst_bresp",  32'(axi.bresp),  32'd0);
        aresetn = 1'b1;
        tick();

        // Arbitration, first pair right after reset: read wins, then write.
        axi.arid = 4'd1; axi.araddr = 32'h3000; axi.arlen = 8'd0; axi.arburst = BURST_INCR; axi.arvalid = 1'b1;
        axi.awid = 4'd2; axi.awaddr = 32'h3004; axi.awlen = 8'd0; axi.awburst = BURST_INCR; axi.awvalid = 1'b1;
        #1;
        check("arb1_arready", 32'(axi.arready), 32'd1);
        check("arb1_awready", 32'(axi.awready), 32'd0);
        tick();
        axi.arvalid = 1'b0;
        check("arb1_rd_first", 32'(axi.rvalid), 32'd1);
        check("arb1_no_aw_busy", 32'(axi.awready), 32'd0);
        r_take(d, last, id);
        check("arb1_rid", 32'(id), 32'd1);
        check("arb1_awready_after", 32'(axi.awready), 32'd1);
        tick();
        axi.awvalid = 1'b0;
        check("arb1_wr_granted", 32'(axi.wready), 32'd1);
        w_beat(32'h5A5A0004, 4'b1111, 1'b1);
        b_take(id, resp);
        check("arb1_bid", 32'(id), 32'd2);
        // A lone read leaves write priority set, so the next pair grants the write.
        rd1(32'h3004, d);
        check("arb_rd_3004", d, 32'h5A5A0004);
        axi.arid = 4'd3; axi.araddr = 32'h3004; axi.arvalid = 1'b1;
        axi.awid = 4'd4; axi.awaddr = 32'h3008; axi.awvalid = 1'b1;
        #1;
        check("arb2_awready", 32'(axi.awready), 32'd1);
        check("arb2_arready", 32'(axi.arready), 32'd0);
        tick();
        axi.awvalid = 1'b0;
        check("arb2_wr_first", 32'(axi.wready), 32'd1);
        check("arb2_no_rvalid", 32'(axi.rvalid), 32'd0);
        w_beat(32'h00003008, 4'b1111, 1'b1);
        b_take(id, resp);
        check("arb2_bid", 32'(id), 32'd4);
        r_take(d, last, id);
        axi.arvalid = 1'b0;
        check("arb2_rid", 32'(id), 32'd3);

        // Single read, one-cycle latency after the AR handshake.
        wr1(32'h1000, 32'hDEADBEEF, 4'b1111);
        ar_send(4'd3, 32'h1000, 8'd0, BURST_INCR);
        check("t1_rvalid", 32'(axi.rvalid), 32'd1);
        check("t1_rdata",  axi.rdata,       32'hDEADBEEF);
        check("t1_rid",    32'(axi.rid),    32'd3);
        check("t1_rlast",  32'(axi.rlast),  32'd1);
        check("t1_rresp",  32'(axi.rresp),  32'd0);
        r_take(d, last, id);

        // Partial-strobe write.
        wr1(32'h2000, 32'hAAAAAAAA, 4'b1111);
        aw_send(4'd5, 32'h2000, 8'd0, BURST_INCR);
        w_beat(32'h12345678, 4'b0011, 1'b1);
        b_take(id, resp);
        check("t2_bid",   32'(id),   32'd5);
        check("t2_bresp", 32'(resp), 32'(RESP_OKAY));
        rd1(32'h2000, d);
        check("t2_data", d, 32'hAAAA5678);

        // INCR burst write, then INCR read with stalls between beats.
        aw_send(4'd6, 32'h100, 8'd3, BURST_INCR);
        for (int b = 0; b < 4; b++) begin
            w_beat(32'hC0DE0000 + 32'(b), 4'b1111, b == 3);
        end
        b_take(id, resp);
        check("t3_wr_bresp", 32'(resp), 32'(RESP_OKAY));
        ar_send(4'd7, 32'h100, 8'd3, BURST_INCR);
        for (int b = 0; b < 4; b++) begin
            check("t3_rvalid", 32'(axi.rvalid), 32'd1);
            check("t3_rid",    32'(axi.rid),    32'd7);
            d_hold = axi.rdata;
            check("t3_data",  d_hold,          32'hC0DE0000 + 32'(b));
            check("t3_rlast", 32'(axi.rlast),  32'(b == 3));
            tick();
            check("t3_stall_data", axi.rdata,      d_hold);
            check("t3_stall_last", 32'(axi.rlast), 32'(b == 3));
            axi.rready = 1'b1;
            tick();
            axi.rready = 1'b0;
            $display("R  id=7 data=%h beat=%0d", d_hold, b);
        end
        check("t3_done_rvalid", 32'(axi.rvalid), 32'd0);

        // Early wlast: all three beats still written, response SLVERR.
        aw_send(4'd9, 32'h500, 8'd2, BURST_INCR);
        w_beat(32'h55000001, 4'b1111, 1'b1);
        w_beat(32'h55000002, 4'b1111, 1'b0);
        check("t5_wready_mid", 32'(axi.wready), 32'd1);
        w_beat(32'h55000003, 4'b1111, 1'b0);
        check("t5_wready_end", 32'(axi.wready), 32'd0);
        check("t5_bvalid",     32'(axi.bvalid), 32'd1);
        b_take(id, resp);
        check("t5_bid",   32'(id),   32'd9);
        check("t5_bresp", 32'(resp), 32'(RESP_SLVERR));
        rd1(32'h500, d); check("t5_w0", d, 32'h55000001);
        rd1(32'h504, d); check("t5_w1", d, 32'h55000002);
        rd1(32'h508, d); check("t5_w2", d, 32'h55000003);

        // FIXED burst: both beats land on the same word.
        wr1(32'h44, 32'h44444444, 4'b1111);
        aw_send(4'd2, 32'h40, 8'd1, BURST_FIXED);
        w_beat(32'd1, 4'b1111, 1'b0);
        w_beat(32'd2, 4'b1111, 1'b1);
        b_take(id, resp);
        check("t6_bresp", 32'(resp), 32'(RESP_OKAY));
        rd1(32'h40, d); check("t6_w40", d, 32'd2);
        rd1(32'h44, d); check("t6_w44", d, 32'h44444444);

        // Word index wraps at the top of the array; high address bits alias.
        aw_send(4'd1, 32'h3FFFC, 8'd1, BURST_INCR);
        w_beat(32'h0F0F0001, 4'b1111, 1'b0);
        w_beat(32'h0F0F0002, 4'b1111, 1'b1);
        b_take(id, resp);
        rd1(32'h0, d);     check("wrap_idx0",  d, 32'h0F0F0002);
        rd1(32'h7FFFC, d); check("alias_top",  d, 32'h0F0F0001);

        // Reset in the middle of a read burst.
        ar_send(4'd8, 32'h100, 8'd3, BURST_INCR);
        axi.rready = 1'b1;
        tick();
        tick();
        check("t7_beat2", axi.rdata, 32'hC0DE0002);
        aresetn = 1'b0;
        tick();
        axi.rready = 1'b0;
        check("t7_rvalid_rst", 32'(axi.rvalid), 32'd0);
        aresetn = 1'b1;
        tick();
        check("t7_arready", 32'(axi.arready), 32'd1);
        check("t7_rvalid_after", 32'(axi.rvalid), 32'd0);
        rd1(32'h104, d); check("t7_ram_104", d, 32'hC0DE0001);
        rd1(32'h10C, d); check("t7_ram_10c", d, 32'hC0DE0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
